// File: rtl/reg_bank_write_pkg.sv
// Purpose   : shared constants and state encoding for the register-file write side and its read mux.
// Latency   : n/a (declarations only).
// Backpress.: n/a.
// Contents  : NUM_REGS, REG_ADDR_W, LANE_W, sweep state enum.
package reg_bank_write_pkg;

    localparam int NUM_REGS   = 16;
    localparam int REG_ADDR_W = 4;
    localparam int LANE_W     = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } sweep_state_t;

    localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(NUM_REGS - 1);

endpackage

// File: rtl/reg_bank_write_if.sv
// Purpose   : write/clear request bundle between the CPU write port and the register file.
// Latency   : n/a (wiring only).
// Backpress.: busy from the slave means requests are dropped, not held.
// Ports     : master drives wr_en/wr_addr/wr_data/wr_byte_en/clr_req; slave drives busy/wr_ack.
interface reg_bank_write_if
    import reg_bank_write_pkg::*;
#(
    parameter int WIDTH = 16
) ();

    logic                  wr_en;
    logic [REG_ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]      wr_data;
    logic [1:0]            wr_byte_en;
    logic                  clr_req;
    logic                  busy;
    logic                  wr_ack;

    modport master (
        output wr_en, wr_addr, wr_data, wr_byte_en, clr_req,
        input  busy, wr_ack
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_byte_en, clr_req,
        output busy, wr_ack
    );

endinterface

// File: rtl/reg_bank_write_decoder.sv
// Purpose   : 4-to-16 one-hot decoder with a global enable.
// Latency   : combinational.
// Backpress.: none; output is all-zero while en is low.
// Ports     : en, addr in; onehot out.
module reg_write_decoder
    import reg_bank_write_pkg::*;
(
    input  logic                  en,
    input  logic [REG_ADDR_W-1:0] addr,
    output logic [NUM_REGS-1:0]   onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_write.sv
// Purpose   : sixteen WIDTH-bit registers with byte-lane masked writes and a one-per-cycle bulk clear.
// Latency   : write visible and wr_ack high the cycle after the sampling edge; clear takes 16 edges.
// Backpress.: while busy, writes and further clear requests are dropped (no ack, no retry).
// Ports     : clk, reset_n, bus (slave: write/clear request, busy, wr_ack), data_out0..data_out15.
module reg_bank_write
    import reg_bank_write_pkg::*;
#(
    parameter int               WIDTH       = 16,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    reg_bank_write_if.slave    bus,
    output logic [WIDTH-1:0]   data_out0,
    output logic [WIDTH-1:0]   data_out1,
    output logic [WIDTH-1:0]   data_out2,
    output logic [WIDTH-1:0]   data_out3,
    output logic [WIDTH-1:0]   data_out4,
    output logic [WIDTH-1:0]   data_out5,
    output logic [WIDTH-1:0]   data_out6,
    output logic [WIDTH-1:0]   data_out7,
    output logic [WIDTH-1:0]   data_out8,
    output logic [WIDTH-1:0]   data_out9,
    output logic [WIDTH-1:0]   data_out10,
    output logic [WIDTH-1:0]   data_out11,
    output logic [WIDTH-1:0]   data_out12,
    output logic [WIDTH-1:0]   data_out13,
    output logic [WIDTH-1:0]   data_out14,
    output logic [WIDTH-1:0]   data_out15
);

    sweep_state_t          state_q;
    sweep_state_t          state_d;
    logic [REG_ADDR_W-1:0] idx_q;
    logic                  wr_ack_q;
    logic                  write_ok;
    logic                  sweeping;
    logic [NUM_REGS-1:0]   wr_hot;
    logic [NUM_REGS-1:0]   clr_hot;
    logic [WIDTH-1:0]      regs [NUM_REGS];

    // A clear request on the same edge as a write takes priority, so the
    // write path is only opened when idle and no clear is being requested.
    assign write_ok = bus.wr_en && (state_q == IDLE) && !bus.clr_req;
    assign sweeping = (state_q == CLEAR);

    reg_write_decoder u_wr_dec (
        .en     (write_ok),
        .addr   (bus.wr_addr),
        .onehot (wr_hot)
    );

    reg_write_decoder u_clr_dec (
        .en     (sweeping),
        .addr   (idx_q),
        .onehot (clr_hot)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.clr_req)     state_d = CLEAR;
            CLEAR:   if (idx_q == LAST_IDX) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // idx only advances during the sweep; the 4-bit counter wraps 15 -> 0
    // on the exit edge, so the next sweep starts at register 0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            wr_ack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ack_q <= write_ok;
            if (sweeping) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Reset forces zero, not CLEAR_VALUE; only the sweep writes CLEAR_VALUE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (clr_hot[i]) begin
                    regs[i] <= CLEAR_VALUE;
                end else if (wr_hot[i]) begin
                    if (bus.wr_byte_en[0]) regs[i][LANE_W-1:0]     <= bus.wr_data[LANE_W-1:0];
                    if (bus.wr_byte_en[1]) regs[i][WIDTH-1:LANE_W] <= bus.wr_data[WIDTH-1:LANE_W];
                end
            end
        end
    end

    assign bus.busy   = sweeping;
    assign bus.wr_ack = wr_ack_q;

    assign data_out0  = regs[0];
    assign data_out1  = regs[1];
    assign data_out2  = regs[2];
    assign data_out3  = regs[3];
    assign data_out4  = regs[4];
    assign data_out5  = regs[5];
    assign data_out6  = regs[6];
    assign data_out7  = regs[7];
    assign data_out8  = regs[8];
    assign data_out9  = regs[9];
    assign data_out10 = regs[10];
    assign data_out11 = regs[11];
    assign data_out12 = regs[12];
    assign data_out13 = regs[13];
    assign data_out14 = regs[14];
    assign data_out15 = regs[15];

endmodule
